// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the external interrupt controller: default sizing,
// FSM state encodings and the CP0 register index that maps onto the enable register.
package intr_ctrl_pkg;

    localparam int IC_N_IRQ = 8;
    localparam int IC_ID_W  = 3;

    // CP0 register number decoded by the EXE-stage store path to drive ien_we.
    localparam logic [4:0] IC_CP0_IEN_REG = 5'd20;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_REQ     = 2'd1,
        IC_SERVICE = 2'd2
    } ic_state_t;

endpackage

// File: rtl/irq_sync.sv
// Vectorised two-flop synchroniser for asynchronous device lines, followed by a
// history flop so each low-to-high transition yields a single-cycle edge pulse.
module irq_sync
    import intr_ctrl_pkg::*;
#(
    parameter int N = IC_N_IRQ
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] async_in,
    output logic [N-1:0] edge_out
);

    logic [N-1:0] s0;
    logic [N-1:0] s1;
    logic [N-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0   <= '0;
            s1   <= '0;
            prev <= '0;
        end else begin
            s0   <= async_in;
            s1   <= s0;
            prev <= s1;
        end
    end

    // A level held high produces exactly one pulse.
    assign edge_out = s1 & ~prev;

endmodule

// File: rtl/intr_ctrl.sv
// External interrupt controller: latches synchronised rising edges as pending,
// masks them with a software enable register and dispatches one at a time to CP0.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int N_IRQ = IC_N_IRQ,
    parameter int ID_W  = IC_ID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             ien_we,
    input  logic [N_IRQ-1:0] ien_wdata,
    output logic [N_IRQ-1:0] ien_q,
    output logic [N_IRQ-1:0] pend_q,
    output logic             ir_req,
    output logic [ID_W-1:0]  ir_id,
    output logic             ir_busy,
    input  logic             eoi,
    output logic [1:0]       state_dbg
);

    // Handshake: ir_req pulses for exactly one cycle when a line is dispatched;
    // ir_busy and ir_id then hold until eoi is sampled high in SERVICE. eoi seen
    // in any other state is dropped and never remembered.

    ic_state_t        state;
    ic_state_t        state_nxt;
    logic [N_IRQ-1:0] edge_det;
    logic [N_IRQ-1:0] pend;
    logic [N_IRQ-1:0] ien;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] clr;
    logic [ID_W-1:0]  win_idx;
    logic             win_any;
    logic             id_load;
    logic             ir_req_nxt;
    logic             ir_busy_nxt;

    irq_sync #(.N(N_IRQ)) u_irq_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (irq_in),
        .edge_out (edge_det)
    );

    assign eligible = pend & ien;

    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        win_idx = '0;
        win_any = |eligible;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        id_load   = 1'b0;
        clr       = '0;
        case (state)
            IC_IDLE: begin
                if (win_any) begin
                    state_nxt = IC_REQ;
                    id_load   = 1'b1;
                    clr       = N_IRQ'(1) << win_idx;
                end
            end
            IC_REQ: begin
                state_nxt = IC_SERVICE;
            end
            IC_SERVICE: begin
                if (eoi) begin
                    state_nxt = IC_IDLE;
                end
            end
            default: begin
                state_nxt = IC_IDLE;
            end
        endcase
        ir_req_nxt  = (state_nxt == IC_REQ);
        ir_busy_nxt = (state_nxt != IC_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IC_IDLE;
            ir_req  <= 1'b0;
            ir_busy <= 1'b0;
            ir_id   <= '0;
            pend    <= '0;
            ien     <= '0;
        end else begin
            state   <= state_nxt;
            ir_req  <= ir_req_nxt;
            ir_busy <= ir_busy_nxt;
            if (id_load) begin
                ir_id <= win_idx;
            end
            // A fresh edge on the line being cleared keeps it pending.
            pend <= (pend & ~clr) | edge_det;
            if (ien_we) begin
                ien <= ien_wdata;
            end
        end
    end

    assign pend_q    = pend;
    assign ien_q     = ien;
    assign state_dbg = state;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a vector table for dispatch, priority and masking,
// plus hand-written sequences for re-trigger, enable-drop and reset mid-service.
module tb_intr_ctrl;
    import intr_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] irq_in;
    logic       ien_we;
    logic [7:0] ien_wdata;
    logic [7:0] ien_q;
    logic [7:0] pend_q;
    logic       ir_req;
    logic [2:0] ir_id;
    logic       ir_busy;
    logic       eoi;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    intr_ctrl #(.N_IRQ(8), .ID_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .ien_we    (ien_we),
        .ien_wdata (ien_wdata),
        .ien_q     (ien_q),
        .pend_q    (pend_q),
        .ir_req    (ir_req),
        .ir_id     (ir_id),
        .ir_busy   (ir_busy),
        .eoi       (eoi),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] irq;
        logic       we;
        logic [7:0] wdata;
        logic       eoi;
        logic [7:0] e_pend;
        logic [7:0] e_ien;
        logic       e_req;
        logic       e_busy;
        logic [2:0] e_id;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(input logic [7:0] irq, input logic we, input logic [7:0] wdata,
                                input logic e, input logic [7:0] p, input logic [7:0] en,
                                input logic rq, input logic bz, input logic [2:0] id);
        vec_t v;
        v.irq = irq; v.we = we; v.wdata = wdata; v.eoi = e;
        v.e_pend = p; v.e_ien = en; v.e_req = rq; v.e_busy = bz; v.e_id = id;
        return v;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] p, input logic [7:0] en,
                              input logic rq, input logic bz);
        check({tag, ".pend"}, {24'd0, pend_q}, {24'd0, p});
        check({tag, ".ien"},  {24'd0, ien_q},  {24'd0, en});
        check({tag, ".req"},  {31'd0, ir_req}, {31'd0, rq});
        check({tag, ".busy"}, {31'd0, ir_busy}, {31'd0, bz});
    endtask

    initial begin
        // Reset block
        rst = 1'b1; irq_in = '0; ien_we = 1'b0; ien_wdata = '0; eoi = 1'b0;
        tick();
        tick();
        check_outs("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        check("reset.id", {29'd0, ir_id}, 32'd0);
        check("reset.state", {30'd0, state_dbg}, {30'd0, IC_IDLE});
        rst = 1'b0;

        //                irq   we  wdata eoi  pend  ien  req busy id
        vecs[0]  = mk(8'h08, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[1]  = mk(8'h08, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[2]  = mk(8'h08, 0, 8'h00, 0, 8'h08, 8'h00, 0, 0, 0);
        vecs[3]  = mk(8'h08, 0, 8'h00, 0, 8'h08, 8'h00, 0, 0, 0);
        vecs[4]  = mk(8'h08, 1, 8'h08, 0, 8'h08, 8'h08, 0, 0, 0);
        vecs[5]  = mk(8'h08, 0, 8'h00, 0, 8'h00, 8'h08, 1, 1, 3);
        vecs[6]  = mk(8'h08, 0, 8'h00, 0, 8'h00, 8'h08, 0, 1, 3);
        vecs[7]  = mk(8'h08, 0, 8'h00, 1, 8'h00, 8'h08, 0, 0, 0);
        vecs[8]  = mk(8'h08, 1, 8'hFF, 0, 8'h00, 8'hFF, 0, 0, 0);
        vecs[9]  = mk(8'h00, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 0, 0);
        vecs[10] = mk(8'h20, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 0, 0);
        vecs[11] = mk(8'h00, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 0, 0);
        vecs[12] = mk(8'h00, 0, 8'h00, 0, 8'h20, 8'hFF, 0, 0, 0);
        vecs[13] = mk(8'h00, 0, 8'h00, 0, 8'h00, 8'hFF, 1, 1, 5);
        vecs[14] = mk(8'h00, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 1, 5);
        vecs[15] = mk(8'h00, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 1, 5);
        vecs[16] = mk(8'h00, 0, 8'h00, 1, 8'h00, 8'hFF, 0, 0, 0);
        vecs[17] = mk(8'h44, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 0, 0);
        vecs[18] = mk(8'h00, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 0, 0);
        vecs[19] = mk(8'h00, 0, 8'h00, 0, 8'h44, 8'hFF, 0, 0, 0);
        vecs[20] = mk(8'h00, 0, 8'h00, 0, 8'h40, 8'hFF, 1, 1, 2);
        vecs[21] = mk(8'h00, 0, 8'h00, 0, 8'h40, 8'hFF, 0, 1, 2);
        vecs[22] = mk(8'h00, 0, 8'h00, 1, 8'h40, 8'hFF, 0, 0, 0);
        vecs[23] = mk(8'h00, 0, 8'h00, 0, 8'h00, 8'hFF, 1, 1, 6);
        vecs[24] = mk(8'h00, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 1, 6);
        vecs[25] = mk(8'h00, 0, 8'h00, 1, 8'h00, 8'hFF, 0, 0, 0);
        vecs[26] = mk(8'h00, 0, 8'h00, 1, 8'h00, 8'hFF, 0, 0, 0);
        vecs[27] = mk(8'h00, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 0, 0);

        for (int i = 0; i < 28; i++) begin
            irq_in = vecs[i].irq; ien_we = vecs[i].we; ien_wdata = vecs[i].wdata; eoi = vecs[i].eoi;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_pend, vecs[i].e_ien, vecs[i].e_req, vecs[i].e_busy);
            if (vecs[i].e_busy)
                check($sformatf("vec%0d.id", i), {29'd0, ir_id}, {29'd0, vecs[i].e_id});
        end
        irq_in = '0; ien_we = 1'b0; eoi = 1'b0;

        // Re-trigger of line 1 while it is in service
        irq_in = 8'h02; tick();
        irq_in = 8'h00; tick();
        tick();
        check_outs("rt.pend", 8'h02, 8'hFF, 1'b0, 1'b0);
        tick();
        check_outs("rt.req1", 8'h00, 8'hFF, 1'b1, 1'b1);
        check("rt.id1", {29'd0, ir_id}, 32'd1);
        tick();
        irq_in = 8'h02;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rt.noreq%0d", k), {31'd0, ir_req}, 32'd0);
        end
        check_outs("rt.repend", 8'h02, 8'hFF, 1'b0, 1'b1);
        eoi = 1'b1; tick(); eoi = 1'b0;
        check_outs("rt.eoi", 8'h02, 8'hFF, 1'b0, 1'b0);
        tick();
        check_outs("rt.req2", 8'h00, 8'hFF, 1'b1, 1'b1);
        check("rt.id2", {29'd0, ir_id}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_outs($sformatf("rt.held%0d", k), 8'h00, 8'hFF, 1'b0, 1'b1);
        end
        eoi = 1'b1; tick(); eoi = 1'b0;
        irq_in = 8'h00;
        check_outs("rt.done", 8'h00, 8'hFF, 1'b0, 1'b0);

        // Enable drop during service, then reset mid-service
        irq_in = 8'h81; tick();
        irq_in = 8'h00; tick();
        tick();
        check_outs("rs.pend", 8'h81, 8'hFF, 1'b0, 1'b0);
        tick();
        check_outs("rs.req", 8'h80, 8'hFF, 1'b1, 1'b1);
        check("rs.id", {29'd0, ir_id}, 32'd0);
        tick();
        irq_in = 8'h01; ien_we = 1'b1; ien_wdata = 8'h00; tick();
        irq_in = 8'h00; ien_we = 1'b0; tick();
        tick();
        check_outs("rs.busy", 8'h81, 8'h00, 1'b0, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_outs("rs.rst", 8'h00, 8'h00, 1'b0, 1'b0);
        check("rs.rst.id", {29'd0, ir_id}, 32'd0);
        check("rs.rst.state", {30'd0, state_dbg}, {30'd0, IC_IDLE});
        for (int k = 0; k < 5; k++) begin
            tick();
            check_outs($sformatf("rs.quiet%0d", k), 8'h00, 8'h00, 1'b0, 1'b0);
        end

        // Masked pending line released by an enable write
        irq_in = 8'h80; tick();
        irq_in = 8'h00; tick();
        tick();
        check_outs("mk.pend", 8'h80, 8'h00, 1'b0, 1'b0);
        tick();
        check_outs("mk.masked", 8'h80, 8'h00, 1'b0, 1'b0);
        ien_we = 1'b1; ien_wdata = 8'h80; tick(); ien_we = 1'b0;
        check_outs("mk.write", 8'h80, 8'h80, 1'b0, 1'b0);
        eoi = 1'b1; tick();
        check_outs("mk.req", 8'h00, 8'h80, 1'b1, 1'b1);
        check("mk.id", {29'd0, ir_id}, 32'd7);
        tick(); eoi = 1'b0;
        check_outs("mk.eoi_in_req", 8'h00, 8'h80, 1'b0, 1'b1);
        tick();
        check_outs("mk.svc", 8'h00, 8'h80, 1'b0, 1'b1);
        eoi = 1'b1; tick(); eoi = 1'b0;
        check_outs("mk.done", 8'h00, 8'h80, 1'b0, 1'b0);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
